// File: rtl/rgb_pwm_fader.sv
// rgb_pwm_fader: CHANNELS-wide LED PWM with per-channel static/fade/breathe/off level control.
// Latency: a write changes the working level in the accept cycle; the duty follows at the next period boundary, and pwm_out is one clock behind cnt.
// Backpressure: wr_ready is held high from the first clock after reset, so every write is taken in a single cycle.
//
// Ports:
//   clk, rst_n                 clock and asynchronous active-low reset
//   wr_valid/wr_ready          write handshake carrying wr_chan, wr_mode, wr_level
//   pwm_out[CHANNELS]          registered PWM outputs, active high
//   period_start               one-cycle pulse aligned with the first output cycle of each period
module rgb_pwm_fader #(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 12000,
  parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [CW-1:0]       wr_chan,
  input  logic [1:0]          wr_mode,
  input  logic [WIDTH-1:0]    wr_level,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_start
);

  typedef enum logic [1:0] {
    M_STATIC  = 2'd0,
    M_FADE    = 2'd1,
    M_BREATHE = 2'd2,
    M_OFF     = 2'd3
  } mode_t;

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] LVL_MAX  = '1;
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] cnt;
  logic [PW-1:0]    pre;
  logic             tick;
  logic             wr_fire;

  assign tick    = (pre == PRE_LAST);
  assign wr_fire = wr_valid && wr_ready;

  // Shared period counter, step prescaler and write-ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      pre          <= '0;
      wr_ready     <= 1'b0;
      period_start <= 1'b0;
    end else begin
      cnt          <= cnt + 1'b1;
      pre          <= tick ? '0 : pre + 1'b1;
      wr_ready     <= 1'b1;
      period_start <= (cnt == '0);
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    localparam logic [CW-1:0] IDX = CW'(i);

    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] target;
    mode_t            mode;
    logic             dir_up;
    logic             pwm_q;
    logic             hit;

    // Out-of-range channel indices never match any IDX, so those writes vanish.
    assign hit        = wr_fire && (wr_chan == IDX);
    assign pwm_out[i] = pwm_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        level  <= '0;
        shadow <= '0;
        target <= '0;
        mode   <= M_OFF;
        dir_up <= 1'b1;
        pwm_q  <= 1'b0;
      end else begin
        // Duty only changes at the period boundary; full scale is forced solid high.
        pwm_q <= (cnt < shadow) || (shadow == LVL_MAX);
        if (cnt == LVL_MAX) shadow <= level;

        // A write on a tick cycle replaces that channel's step for this cycle.
        if (hit) begin
          target <= wr_level;
          mode   <= mode_t'(wr_mode);
          case (mode_t'(wr_mode))
            M_STATIC:  level <= wr_level;
            M_FADE:    level <= level;
            M_BREATHE: begin
              level  <= '0;
              dir_up <= 1'b1;
            end
            M_OFF:     level <= '0;
          endcase
        end else if (tick) begin
          case (mode)
            M_STATIC: level <= target;
            M_FADE: begin
              if (level < target)      level <= level + 1'b1;
              else if (level > target) level <= level - 1'b1;
            end
            M_BREATHE: begin
              if (target == '0) begin
                level <= '0;
              end else if (dir_up) begin
                // Turn around on the tick that reaches the target.
                if (level < target) begin
                  level  <= level + 1'b1;
                  dir_up <= ((level + 1'b1) != target);
                end else begin
                  dir_up <= 1'b0;
                end
              end else begin
                if (level > '0) begin
                  level  <= level - 1'b1;
                  dir_up <= (level == WIDTH'(1));
                end else begin
                  dir_up <= 1'b1;
                end
              end
            end
            M_OFF: level <= '0;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// tb_rgb_pwm_fader: directed plus random checks of rgb_pwm_fader against a cycle-stepped reference model.
// Latency: the model advances once per rising edge and outputs are compared 1 time unit later.
// Backpressure: none modelled beyond wr_ready, which the model expects high after the first post-reset clock.
module tb_rgb_pwm_fader;

  localparam int C = 3;
  localparam int W = 4;
  localparam int P = 4;
  localparam int M = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         wr_valid = 1'b0;
  logic         wr_ready;
  logic [1:0]   wr_chan = '0;
  logic [1:0]   wr_mode = '0;
  logic [W-1:0] wr_level = '0;
  logic [C-1:0] pwm_out;
  logic         period_start;

  int total = 0;
  int bad = 0;

  // Reference model state: plain integers following the behavioural rules.
  int cnt_m, pre_m;
  int lvl [C];
  int shd [C];
  int tgt [C];
  int md  [C];
  bit up  [C];
  bit rdy_m;
  bit last_eps;

  rgb_pwm_fader #(.CHANNELS(C), .WIDTH(W), .PRESCALE(P)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_chan(wr_chan), .wr_mode(wr_mode), .wr_level(wr_level),
    .pwm_out(pwm_out), .period_start(period_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cnt_m = 0; pre_m = 0; rdy_m = 0; last_eps = 0;
    for (int c = 0; c < C; c++) begin
      lvl[c] = 0; shd[c] = 0; tgt[c] = 0; md[c] = 3; up[c] = 1;
    end
  endtask

  task automatic model_write(input int c);
    tgt[c] = int'(wr_level);
    md[c]  = int'(wr_mode);
    case (md[c])
      0: lvl[c] = tgt[c];
      2: begin lvl[c] = 0; up[c] = 1; end
      3: lvl[c] = 0;
      default: ;
    endcase
  endtask

  task automatic model_tick(input int c);
    case (md[c])
      0: lvl[c] = tgt[c];
      1: if (lvl[c] < tgt[c]) lvl[c]++; else if (lvl[c] > tgt[c]) lvl[c]--;
      2: begin
        if (tgt[c] == 0) lvl[c] = 0;
        else if (up[c]) begin
          lvl[c]++;
          if (lvl[c] >= tgt[c]) begin lvl[c] = tgt[c]; up[c] = 0; end
        end else begin
          lvl[c]--;
          if (lvl[c] <= 0) begin lvl[c] = 0; up[c] = 1; end
        end
      end
      default: lvl[c] = 0;
    endcase
  endtask

  // One clock: advance the model from the pre-edge state, then compare outputs.
  task automatic cyc();
    logic [C-1:0] ep;
    logic eps;
    bit tk, acc;
    @(posedge clk);
    for (int c = 0; c < C; c++) ep[c] = (cnt_m < shd[c]) || (shd[c] == M);
    eps = (cnt_m == 0);
    tk  = (pre_m == P - 1);
    acc = wr_valid && rdy_m;
    if (cnt_m == M) for (int c = 0; c < C; c++) shd[c] = lvl[c];
    for (int c = 0; c < C; c++) begin
      if (acc && int'(wr_chan) == c) model_write(c);
      else if (tk) model_tick(c);
    end
    cnt_m = (cnt_m + 1) % (M + 1);
    pre_m = (pre_m + 1) % P;
    rdy_m = 1;
    #1;
    check("pwm_out", 32'(pwm_out), 32'(ep));
    check("period_start", 32'(period_start), 32'(eps));
    check("wr_ready", 32'(wr_ready), 32'(rdy_m));
    last_eps = eps;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic wr(input int ch, input int mode, input int level);
    wr_valid = 1'b1;
    wr_chan  = 2'(ch);
    wr_mode  = 2'(mode);
    wr_level = W'(level);
    cyc();
    wr_valid = 1'b0;
  endtask

  // Count high cycles of pwm_out[0] over one full period aligned to period_start.
  task automatic duty0(input string tag, input int exp);
    int hi = 0;
    int guard = 0;
    while (!last_eps && guard < 40) begin cyc(); guard++; end
    check({tag, "_align"}, 32'(last_eps), 32'd1);
    for (int k = 0; k < 16; k++) begin
      if (pwm_out[0]) hi++;
      if (k < 15) cyc();
    end
    check(tag, 32'(hi), 32'(exp));
  endtask

  initial begin
    int guard;
    model_reset();
    #2;
    check("rst_pwm", 32'(pwm_out), 32'd0);
    check("rst_period_start", 32'(period_start), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    #10 rst_n = 1'b1;
    run(40);

    // Static levels, written mid-period.
    run(5);
    wr(0, 0, 5);
    run(20);
    duty0("duty_static5", 5);
    wr(0, 0, 15);
    run(20);
    duty0("duty_static15", 16);
    wr(0, 0, 0);
    run(20);
    duty0("duty_static0", 0);

    // Fade up then down, breathing.
    wr(1, 1, 3);
    run(40);
    wr(1, 1, 0);
    run(40);
    wr(2, 2, 2);
    run(120);

    // Out-of-range channel: accepted, nothing changes.
    check("oor_ready", 32'(wr_ready), 32'd1);
    wr(3, 0, 9);
    run(40);

    // Write landing on a tick while the channel is fading.
    wr(0, 1, 12);
    run(9);
    guard = 0;
    while (pre_m != P - 1 && guard < 8) begin cyc(); guard++; end
    check("tick_align", 32'(pre_m), 32'(P - 1));
    wr(0, 1, 12);
    run(60);

    // Randomized writes.
    for (int k = 0; k < 400; k++) begin
      wr_valid = ($urandom_range(0, 3) == 0);
      wr_chan  = 2'($urandom_range(0, 3));
      wr_mode  = 2'($urandom_range(0, 3));
      wr_level = W'($urandom_range(0, M));
      cyc();
    end
    wr_valid = 1'b0;

    // Reset mid-period with channel 0 driving high.
    wr(0, 0, 9);
    run(20);
    guard = 0;
    while (cnt_m != 3 && guard < 20) begin cyc(); guard++; end
    check("pre_reset_pwm0", 32'(pwm_out[0]), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_pwm", 32'(pwm_out), 32'd0);
    check("async_rst_period_start", 32'(period_start), 32'd0);
    check("async_rst_wr_ready", 32'(wr_ready), 32'd0);
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    run(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
